// File: rtl/clock_enable_synth_pkg.sv
// Shared types for the multi-channel NCO clock-enable generator.
// Latency: n/a (types and a width helper only).
// Backpressure: n/a.
package clock_enable_synth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } meas_state_e;

    // Select width for a channel index; a single channel still needs one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nco_channel.sv
// One phase-accumulator NCO channel: tick strobe plus divided square wave.
// Latency: en registered one edge after the accumulator carry; clk_out toggles on the same edge.
// Backpressure: one pending increment; pend stays high until it is applied, and the parent stalls writes meanwhile.
// Ports: clk/rst (async active-high), sync (realign), wr/wr_inc (accepted config write),
//        pend (update waiting), en (tick strobe), clk_out (toggles every tick).
module nco_channel
    import clock_enable_synth_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             wr,
    input  logic [ACC_W-1:0] wr_inc,
    output logic             pend,
    output logic             en,
    output logic             clk_out
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] pend_inc;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             inc_zero;

    assign sum      = {1'b0, acc} + {1'b0, inc};
    assign carry    = sum[ACC_W];
    assign inc_zero = (inc == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            inc      <= '0;
            pend_inc <= '0;
            pend     <= 1'b0;
            en       <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            if (sync) begin
                // Realign: phase restarts from zero and a waiting rate takes effect now.
                acc     <= '0;
                en      <= 1'b0;
                clk_out <= 1'b0;
                if (pend) begin
                    inc  <= pend_inc;
                    pend <= 1'b0;
                end
            end else begin
                en <= carry;
                if (carry) begin
                    clk_out <= ~clk_out;
                end
                if (pend && inc_zero) begin
                    // A stopped channel has no tick to wait for; restart phase from zero.
                    inc  <= pend_inc;
                    acc  <= '0;
                    pend <= 1'b0;
                end else begin
                    acc <= sum[ACC_W-1:0];
                    // Swapping rate only on a carry keeps the tick spacing glitch-free.
                    if (pend && carry) begin
                        inc  <= pend_inc;
                        pend <= 1'b0;
                    end
                end
            end
            // The parent only writes when pend is low, so this never overwrites a waiting value.
            if (wr) begin
                pend     <= 1'b1;
                pend_inc <= wr_inc;
            end
        end
    end

endmodule

// File: rtl/clock_enable_synth.sv
// Multi-channel fractional clock-enable generator with a tick-count measurement unit.
// Latency: en_o one edge after carry; meas_done_o len+1 cycles after the start edge (1 if len = 0).
// Backpressure: cfg_ready_o drops while the addressed channel holds a pending increment.
// Ports: clk_i/rst_i; cfg_valid_i/cfg_ready_o/cfg_chan_i/cfg_inc_i config handshake; sync_i realign;
//        en_o/clk_o per-channel outputs; meas_start_i/meas_chan_i/meas_len_i start a window,
//        meas_busy_o/meas_done_o/meas_count_o report it.
module clock_enable_synth
    import clock_enable_synth_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int ACC_W    = 16,
    parameter int WINDOW_W = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [chan_w(CHANNELS)-1:0]   cfg_chan_i,
    input  logic [ACC_W-1:0]              cfg_inc_i,
    input  logic                          sync_i,
    output logic [CHANNELS-1:0]           en_o,
    output logic [CHANNELS-1:0]           clk_o,
    input  logic                          meas_start_i,
    input  logic [chan_w(CHANNELS)-1:0]   meas_chan_i,
    input  logic [WINDOW_W-1:0]           meas_len_i,
    output logic                          meas_busy_o,
    output logic                          meas_done_o,
    output logic [WINDOW_W-1:0]           meas_count_o
);

    localparam int CHAN_W = chan_w(CHANNELS);

    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] wr;

    // Out-of-range channel numbers see ready high and match no channel, so they are dropped.
    always_comb begin
        cfg_ready_o = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cfg_chan_i == CHAN_W'(c)) begin
                cfg_ready_o = !pend[c];
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign wr[c] = cfg_valid_i && cfg_ready_o && (cfg_chan_i == CHAN_W'(c));

        nco_channel #(
            .ACC_W (ACC_W)
        ) u_nco (
            .clk     (clk_i),
            .rst     (rst_i),
            .sync    (sync_i),
            .wr      (wr[c]),
            .wr_inc  (cfg_inc_i),
            .pend    (pend[c]),
            .en      (en_o[c]),
            .clk_out (clk_o[c])
        );
    end

    // Measurement unit
    meas_state_e         state;
    meas_state_e         state_nxt;
    logic [CHAN_W-1:0]   m_chan;
    logic [WINDOW_W-1:0] rem;
    logic [WINDOW_W-1:0] cnt;
    logic [WINDOW_W-1:0] cnt_nxt;
    logic                sel_en;

    always_comb begin
        sel_en = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (m_chan == CHAN_W'(c)) begin
                sel_en = en_o[c];
            end
        end
    end

    // Saturating count of ticks seen in the window.
    assign cnt_nxt = (sel_en && (cnt != '1)) ? cnt + WINDOW_W'(1) : cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (meas_start_i) begin
                    state_nxt = (meas_len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rem == WINDOW_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            m_chan       <= '0;
            rem          <= '0;
            cnt          <= '0;
            meas_count_o <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (meas_start_i) begin
                        m_chan <= meas_chan_i;
                        rem    <= meas_len_i;
                        cnt    <= '0;
                        if (meas_len_i == '0) begin
                            meas_count_o <= '0;
                        end
                    end
                end
                RUN: begin
                    rem <= rem - WINDOW_W'(1);
                    cnt <= cnt_nxt;
                    // Result is loaded on entry to DONE so it is valid alongside the done strobe.
                    if (rem == WINDOW_W'(1)) begin
                        meas_count_o <= cnt_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign meas_busy_o = (state != IDLE);
    assign meas_done_o = (state == DONE);

endmodule

// File: tb/tb_clock_enable_synth.sv
// Directed bench for clock_enable_synth: tick timing, rate updates, sync, measurement, reset.
// Expected tick edges and measurement results are queued as stimulus is driven.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_clock_enable_synth;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_valid_i;
    logic        cfg_ready_o;
    logic [1:0]  cfg_chan_i;
    logic [15:0] cfg_inc_i;
    logic        sync_i;
    logic [3:0]  en_o;
    logic [3:0]  clk_o;
    logic        meas_start_i;
    logic [1:0]  meas_chan_i;
    logic [15:0] meas_len_i;
    logic        meas_busy_o;
    logic        meas_done_o;
    logic [15:0] meas_count_o;

    clock_enable_synth #(.CHANNELS(4), .ACC_W(16), .WINDOW_W(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_chan_i   (cfg_chan_i),
        .cfg_inc_i    (cfg_inc_i),
        .sync_i       (sync_i),
        .en_o         (en_o),
        .clk_o        (clk_o),
        .meas_start_i (meas_start_i),
        .meas_chan_i  (meas_chan_i),
        .meas_len_i   (meas_len_i),
        .meas_busy_o  (meas_busy_o),
        .meas_done_o  (meas_done_o),
        .meas_count_o (meas_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int   ch;
        int   edge_n;
        logic chk_clk;
        logic clkv;
    } tick_t;

    tick_t       tq[$];
    logic [15:0] mq[$];
    int passed = 0;
    int total  = 0;
    int edges  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        edges++;
        @(negedge clk_i);
    endtask

    task automatic push_tick(input int ch, input int e, input logic cc, input logic cv);
        tick_t t;
        t.ch = ch; t.edge_n = e; t.chk_clk = cc; t.clkv = cv;
        tq.push_back(t);
    endtask

    // Watch the masked channels for n edges; every tick must match the oldest queued entry.
    task automatic collect(input logic [3:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            for (int c = 0; c < 4; c++) begin
                if (mask[c] && en_o[c]) begin
                    int idx;
                    tick_t t;
                    idx = -1;
                    foreach (tq[k]) if (idx < 0 && tq[k].ch == c) idx = k;
                    if (idx >= 0) begin
                        t = tq[idx];
                        tq.delete(idx);
                        check($sformatf("ch%0d tick edge", c), edges, t.edge_n);
                        if (t.chk_clk) check($sformatf("ch%0d clk_o at tick", c), clk_o[c], t.clkv);
                    end else begin
                        check($sformatf("ch%0d unexpected tick at edge %0d", c, edges), en_o[c], 1'b0);
                    end
                end
            end
        end
        check("expected ticks all seen", tq.size(), 0);
        tq.delete();
    endtask

    task automatic measure(input logic [1:0] ch, input logic [15:0] len, input logic [15:0] exp);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        mq.push_back(exp);
        meas_start_i = 1'b1;
        meas_chan_i  = ch;
        meas_len_i   = len;
        tick();
        meas_start_i = 1'b0;
        for (int i = 0; i < int'(len) + 20; i++) begin
            if (meas_busy_o) busy_cnt++;
            if (meas_done_o) begin
                done_cnt++;
                if (mq.size() > 0) check($sformatf("meas ch%0d count", ch), meas_count_o, mq.pop_front());
            end
            if (!meas_busy_o) break;
            tick();
        end
        check($sformatf("meas ch%0d busy cycles", ch), busy_cnt, int'(len) + 1);
        check($sformatf("meas ch%0d done strobes", ch), done_cnt, 1);
        check("meas result delivered", mq.size(), 0);
        check($sformatf("meas ch%0d count held", ch), meas_count_o, exp);
        mq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int found;
        int done_seen;
        int en_seen;

        rst_i = 1'b0; cfg_valid_i = 1'b0; cfg_chan_i = '0; cfg_inc_i = '0;
        sync_i = 1'b0; meas_start_i = 1'b0; meas_chan_i = '0; meas_len_i = '0;
        #1 rst_i = 1'b1;
        #1;
        check("reset en_o", en_o, 4'h0);
        check("reset clk_o", clk_o, 4'h0);
        check("reset busy", meas_busy_o, 1'b0);
        check("reset done", meas_done_o, 1'b0);
        check("reset count", meas_count_o, 16'd0);
        check("reset cfg_ready", cfg_ready_o, 1'b1);
        tick();
        tick();
        rst_i = 1'b0;

        // ch0 half rate: applied next edge, ticks 2 edges after that, then every 2.
        cfg_valid_i = 1'b1; cfg_chan_i = 2'd0; cfg_inc_i = 16'h8000;
        check("ch0 first write ready", cfg_ready_o, 1'b1);
        tick();
        t0 = edges;
        cfg_valid_i = 1'b0;
        push_tick(0, t0 + 3, 1'b1, 1'b1);
        push_tick(0, t0 + 5, 1'b1, 1'b0);
        push_tick(0, t0 + 7, 1'b1, 1'b1);
        push_tick(0, t0 + 9, 1'b1, 1'b0);
        collect(4'b0001, 10);

        // ch1 at 3/8 rate: any 800-cycle window holds exactly 300 ticks.
        cfg_valid_i = 1'b1; cfg_chan_i = 2'd1; cfg_inc_i = 16'h6000;
        tick();
        cfg_valid_i = 1'b0;
        tick(); tick(); tick();
        measure(2'd1, 16'd800, 16'd300);

        // ch0 to quarter rate, then a mid-period write back to half rate.
        cfg_valid_i = 1'b1; cfg_chan_i = 2'd0; cfg_inc_i = 16'h4000;
        check("ch0 quarter write ready", cfg_ready_o, 1'b1);
        tick();
        cfg_valid_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cfg_ready_o) break;
            tick();
        end
        check("ch0 quarter rate applied", cfg_ready_o, 1'b1);
        found = 0;
        t0 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (en_o[0]) begin
                t0 = edges;
                found = 1;
                break;
            end
        end
        check("ch0 quarter-rate tick seen", found, 1);
        tick();
        cfg_valid_i = 1'b1; cfg_chan_i = 2'd0; cfg_inc_i = 16'h8000;
        check("ch0 mid-period write ready", cfg_ready_o, 1'b1);
        tick();
        cfg_inc_i = 16'h2000;
        check("ch0 second write stalled", cfg_ready_o, 1'b0);
        tick();
        check("ch0 still stalled", cfg_ready_o, 1'b0);
        cfg_valid_i = 1'b0;
        push_tick(0, t0 + 4, 1'b0, 1'b0);
        push_tick(0, t0 + 6, 1'b0, 1'b0);
        push_tick(0, t0 + 8, 1'b0, 1'b0);
        push_tick(0, t0 + 10, 1'b0, 1'b0);
        collect(4'b0001, 8);

        // ch2 stopped: no ticks; then start it from zero phase.
        measure(2'd2, 16'd50, 16'd0);
        cfg_valid_i = 1'b1; cfg_chan_i = 2'd2; cfg_inc_i = 16'h8000;
        tick();
        t0 = edges;
        cfg_valid_i = 1'b0;
        push_tick(2, t0 + 3, 1'b1, 1'b1);
        push_tick(2, t0 + 5, 1'b1, 1'b0);
        collect(4'b0100, 6);

        // ch0 quarter, ch1 eighth rate, then realign with sync.
        cfg_valid_i = 1'b1; cfg_chan_i = 2'd0; cfg_inc_i = 16'h4000;
        tick();
        cfg_chan_i = 2'd1; cfg_inc_i = 16'h2000;
        tick();
        cfg_valid_i = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        sync_i = 1'b1;
        tick();
        t0 = edges;
        sync_i = 1'b0;
        check("sync clk_o cleared", clk_o, 4'h0);
        check("sync en_o cleared", en_o, 4'h0);
        push_tick(0, t0 + 4, 1'b1, 1'b1);
        push_tick(0, t0 + 8, 1'b1, 1'b0);
        push_tick(1, t0 + 8, 1'b1, 1'b1);
        push_tick(0, t0 + 12, 1'b1, 1'b1);
        push_tick(0, t0 + 16, 1'b1, 1'b0);
        push_tick(1, t0 + 16, 1'b1, 1'b0);
        collect(4'b0011, 17);

        // Reset during a running measurement with a pending ch0 update.
        meas_start_i = 1'b1; meas_chan_i = 2'd1; meas_len_i = 16'd100;
        cfg_valid_i = 1'b1; cfg_chan_i = 2'd0; cfg_inc_i = 16'h1000;
        tick();
        meas_start_i = 1'b0;
        cfg_valid_i = 1'b0;
        check("measurement running", meas_busy_o, 1'b1);
        check("ch0 update pending", cfg_ready_o, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        check("async reset en_o", en_o, 4'h0);
        check("async reset clk_o", clk_o, 4'h0);
        check("async reset busy", meas_busy_o, 1'b0);
        check("async reset done", meas_done_o, 1'b0);
        done_seen = 0;
        en_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (meas_done_o) done_seen++;
        end
        rst_i = 1'b0;
        check("ready after reset release", cfg_ready_o, 1'b1);
        for (int i = 0; i < 120; i++) begin
            tick();
            if (meas_done_o) done_seen++;
            if (en_o != 4'h0) en_seen++;
        end
        check("no done after reset", done_seen, 0);
        check("pending update discarded", en_seen, 0);
        check("idle after reset", meas_busy_o, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
